// File: rtl/oc_chunk_sequencer_pkg.sv
// oc_chunk_sequencer_pkg
//   Shared constants and state type for the chunked ones-count sequencer.
//   OC_W      : width of one chunk presented to the 15-input ones counter
//   OC_SUM_W  : width of the ones counter's sum output
//   oc_state_e: sequencer FSM states (IDLE=0, RUN=1, DONE=2)
package oc_chunk_sequencer_pkg;

  localparam int unsigned OC_W     = 15;
  localparam int unsigned OC_SUM_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } oc_state_e;

endpackage

// File: rtl/oc_chunk_sequencer_oc15.sv
// my_oc_fifteen
//   Combinational ones counter for a single 15-bit chunk.
//   Ports:
//     bits  in   OC_W      chunk to count
//     sum   out  OC_SUM_W  number of ones in bits (0..15)
module my_oc_fifteen
  import oc_chunk_sequencer_pkg::*;
(
  input  logic [OC_W-1:0]     bits,
  output logic [OC_SUM_W-1:0] sum
);

  always_comb begin
    sum = '0;
    for (int unsigned i = 0; i < OC_W; i++) begin
      sum = sum + OC_SUM_W'(bits[i]);
    end
  end

endmodule

// File: rtl/oc_chunk_sequencer.sv
// oc_chunk_sequencer
//   Sequential ones-count controller. Latches a word of NCHUNK x 15 bits,
//   feeds one 15-bit chunk per clock into a single my_oc_fifteen counter and
//   accumulates the partial sums. Handshake: start / busy / done.
//   Parameters:
//     NCHUNK  chunks per word (data width = NCHUNK*15)
//     CNT_W   count width, clog2(NCHUNK*15+1)
//   Ports:
//     clk      in   1      rising-edge clock
//     rst_n    in   1      asynchronous active-low reset
//     start    in   1      request, accepted in IDLE or DONE
//     data_in  in   W      word to count, sampled with an accepted start
//     busy     out  1      high while chunks are being counted
//     done     out  1      one-cycle pulse, count valid
//     count    out  CNT_W  popcount of the last completed word (held)
//   Optional feature (macro OC_SEQ_THRESH_EN):
//     thresh   in   CNT_W  threshold, sampled at the done edge
//     above    out  1      registered (count >= thresh), held like count
module oc_chunk_sequencer
  import oc_chunk_sequencer_pkg::*;
#(
  parameter int unsigned NCHUNK = 4,
  parameter int unsigned CNT_W  = 6
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [NCHUNK*OC_W-1:0] data_in,
`ifdef OC_SEQ_THRESH_EN
  input  logic [CNT_W-1:0]       thresh,
  output logic                   above,
`endif
  output logic                   busy,
  output logic                   done,
  output logic [CNT_W-1:0]       count
);

  localparam int unsigned W     = NCHUNK * OC_W;
  localparam int unsigned IDX_W = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  oc_state_e             state_q;
  oc_state_e             state_d;
  logic [W-1:0]          data_q;
  logic [IDX_W-1:0]      idx_q;
  logic [CNT_W-1:0]      acc_q;
  logic [CNT_W-1:0]      count_q;

  logic [OC_W-1:0]       chunk;
  logic [OC_SUM_W-1:0]   oc_sum;
  logic [CNT_W-1:0]      acc_sum;
  logic                  accept;
  logic                  last;

  assign accept  = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign last    = (idx_q == IDX_W'(NCHUNK - 1));
  assign acc_sum = acc_q + CNT_W'(oc_sum);

  // Chunk mux written as a compare-select loop so a non-power-of-two
  // NCHUNK never produces an out-of-range part select.
  always_comb begin
    chunk = '0;
    for (int unsigned i = 0; i < NCHUNK; i++) begin
      if (idx_q == IDX_W'(i)) begin
        chunk = data_q[OC_W*i +: OC_W];
      end
    end
  end

  my_oc_fifteen u_oc (
    .bits (chunk),
    .sum  (oc_sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN:  if (last)  state_d = ST_DONE;
      ST_DONE: state_d = start ? ST_RUN : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // The last chunk's sum is folded straight into count so the result
  // appears on the same edge that raises done; idx holds at the last
  // chunk instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      idx_q   <= '0;
      acc_q   <= '0;
      count_q <= '0;
    end else if (accept) begin
      data_q <= data_in;
      idx_q  <= '0;
      acc_q  <= '0;
    end else if (state_q == ST_RUN) begin
      acc_q <= acc_sum;
      if (last) begin
        count_q <= acc_sum;
      end else begin
        idx_q <= idx_q + 1'b1;
      end
    end
  end

`ifdef OC_SEQ_THRESH_EN
  logic above_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      above_q <= 1'b0;
    end else if ((state_q == ST_RUN) && last && !accept) begin
      above_q <= (acc_sum >= thresh);
    end
  end

  assign above = above_q;
`endif

  assign busy  = (state_q == ST_RUN);
  assign done  = (state_q == ST_DONE);
  assign count = count_q;

endmodule

// File: tb/tb_oc_chunk_sequencer.sv
// tb_oc_chunk_sequencer
//   Self-checking bench for oc_chunk_sequencer: a fixed vector table,
//   randomized words against a bit-counting reference model, and
//   hand-written back-to-back and mid-run reset sequences.
module tb_oc_chunk_sequencer;

  localparam int unsigned NCHUNK = 4;
  localparam int unsigned CNT_W  = 6;
  localparam int unsigned W      = NCHUNK * 15;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b1;
  logic             start = 1'b0;
  logic [W-1:0]     data_in = '0;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] count;
`ifdef OC_SEQ_THRESH_EN
  logic [CNT_W-1:0] thresh = '0;
  logic             above;
  logic             model_above = 1'b0;
`endif

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned model_count = 0;

  typedef struct {
    logic [W-1:0] data;
    int unsigned  exp_cnt;
  } vec_t;

  vec_t vecs[7];

  always #5 clk = ~clk;

  oc_chunk_sequencer #(
    .NCHUNK (NCHUNK),
    .CNT_W  (CNT_W)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .data_in (data_in),
`ifdef OC_SEQ_THRESH_EN
    .thresh  (thresh),
    .above   (above),
`endif
    .busy    (busy),
    .done    (done),
    .count   (count)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int unsigned pop(input logic [W-1:0] d);
    int unsigned n = 0;
    for (int i = 0; i < int'(W); i++) begin
      if (d[i]) n++;
    end
    return n;
  endfunction

  // Called at a negedge with the DUT idle; returns at a negedge one cycle
  // after the done pulse.
  task automatic run_word(input string name, input logic [W-1:0] d, input int unsigned exp_cnt);
    int unsigned edges;
    logic [63:0] junk;
    start   = 1'b1;
    data_in = d;
    @(posedge clk);
    @(negedge clk);
    start   = 1'b0;
    junk    = {$urandom(), $urandom()};
    data_in = junk[W-1:0];
    check({name, "/busy_after_accept"}, 64'(busy), 64'd1);
    check({name, "/done_after_accept"}, 64'(done), 64'd0);
    edges = 0;
    while (!done && edges < 20) begin
      check({name, "/count_held_run"}, 64'(count), 64'(model_count));
      @(posedge clk);
      @(negedge clk);
      edges++;
    end
    check({name, "/latency"}, 64'(edges), 64'(NCHUNK));
    check({name, "/done_pulse"}, 64'(done), 64'd1);
    check({name, "/busy_at_done"}, 64'(busy), 64'd0);
    check({name, "/count"}, 64'(count), 64'(exp_cnt));
    model_count = exp_cnt;
`ifdef OC_SEQ_THRESH_EN
    model_above = (exp_cnt >= int'(thresh));
    check({name, "/above"}, 64'(above), 64'(model_above));
`endif
    @(posedge clk);
    @(negedge clk);
    check({name, "/done_falls"}, 64'(done), 64'd0);
    check({name, "/idle_busy"}, 64'(busy), 64'd0);
    check({name, "/count_held_idle"}, 64'(count), 64'(model_count));
`ifdef OC_SEQ_THRESH_EN
    check({name, "/above_held"}, 64'(above), 64'(model_above));
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] r1;
    logic [63:0] r2;
    logic [W-1:0] d;
    logic [W-1:0] wa;
    logic [W-1:0] wb;
    int unsigned edges;

    vecs[0] = '{60'hFFF_FFFF_FFFF_FFFF, 60};
    vecs[1] = '{60'h000_0000_0000_7FFF, 15};
    vecs[2] = '{60'hAAA_AAAA_AAAA_AAAA, 30};
    vecs[3] = '{60'h000_0000_0000_0000, 0};
    vecs[4] = '{60'h800_0000_0000_0001, 2};
    vecs[5] = '{60'h000_0000_7FFF_8000, 16};
    vecs[6] = '{60'h123_4567_89AB_CDEF, 32};

    // Reset and idle
    #1 rst_n = 1'b0;
    #2;
    check("reset/busy", 64'(busy), 64'd0);
    check("reset/done", 64'(done), 64'd0);
    check("reset/count", 64'(count), 64'd0);
`ifdef OC_SEQ_THRESH_EN
    check("reset/above", 64'(above), 64'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      r1 = {$urandom(), $urandom()};
      data_in = r1[W-1:0];
      @(posedge clk);
      @(negedge clk);
      check("idle/busy", 64'(busy), 64'd0);
      check("idle/done", 64'(done), 64'd0);
      check("idle/count", 64'(count), 64'd0);
    end

    // Fixed vector table
    for (int i = 0; i < 7; i++) begin
`ifdef OC_SEQ_THRESH_EN
      thresh = CNT_W'($urandom_range(0, 63));
`endif
      run_word($sformatf("vec%0d", i), vecs[i].data, vecs[i].exp_cnt);
    end

    // Randomized words against the bit-count model
    for (int i = 0; i < 24; i++) begin
      r1 = {$urandom(), $urandom()};
      r2 = {$urandom(), $urandom()};
      case (i % 3)
        0:       d = r1[W-1:0];
        1:       d = r1[W-1:0] & r2[W-1:0];
        default: d = r1[W-1:0] | r2[W-1:0];
      endcase
`ifdef OC_SEQ_THRESH_EN
      thresh = CNT_W'($urandom_range(0, 63));
`endif
      run_word($sformatf("rand%0d", i), d, pop(d));
    end

    // start held high through RUN: second word accepted in DONE
    wa = vecs[0].data;
    wb = vecs[1].data;
    start   = 1'b1;
    data_in = wa;
    @(posedge clk);
    @(negedge clk);
    data_in = wb;
    check("b2b/busy_first", 64'(busy), 64'd1);
    edges = 0;
    while (!done && edges < 20) begin
      @(posedge clk);
      @(negedge clk);
      edges++;
    end
    check("b2b/latency_first", 64'(edges), 64'(NCHUNK));
    check("b2b/count_first", 64'(count), 64'(pop(wa)));
    model_count = pop(wa);
    @(posedge clk);
    @(negedge clk);
    check("b2b/reaccept_busy", 64'(busy), 64'd1);
    check("b2b/reaccept_done", 64'(done), 64'd0);
    check("b2b/count_held", 64'(count), 64'(model_count));
    data_in = vecs[2].data;
    edges = 0;
    while (!done && edges < 20) begin
      @(posedge clk);
      @(negedge clk);
      edges++;
    end
    start = 1'b0;
    check("b2b/latency_second", 64'(edges), 64'(NCHUNK));
    check("b2b/count_second", 64'(count), 64'(pop(wb)));
    model_count = pop(wb);
    @(posedge clk);
    @(negedge clk);
    check("b2b/idle_done", 64'(done), 64'd0);
    check("b2b/idle_busy", 64'(busy), 64'd0);
    check("b2b/idle_count", 64'(count), 64'(model_count));

    // Reset between E2 and E3
    start   = 1'b1;
    data_in = vecs[2].data;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst/busy", 64'(busy), 64'd0);
    check("midrst/done", 64'(done), 64'd0);
    check("midrst/count", 64'(count), 64'd0);
    model_count = 0;
`ifdef OC_SEQ_THRESH_EN
    check("midrst/above", 64'(above), 64'd0);
`endif
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("midrst/no_done", 64'(done), 64'd0);
      check("midrst/no_busy", 64'(busy), 64'd0);
      check("midrst/count_zero", 64'(count), 64'd0);
    end
    run_word("after_rst", vecs[2].data, 30);

`ifdef OC_SEQ_THRESH_EN
    thresh = CNT_W'(30);
    run_word("thresh30", vecs[2].data, 30);
    check("thresh30/above_one", 64'(above), 64'd1);
    thresh = CNT_W'(31);
    run_word("thresh31", vecs[2].data, 30);
    check("thresh31/above_zero", 64'(above), 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
